// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared fetch/decode types and constants
package instr_fetch_pkg;

  localparam int INSTR_W      = 16;
  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_RESET_PC = 0;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_counter.sv
// rtl/pc_counter.sv - program counter with redirect load and modulo increment
module pc_counter
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int RESET_PC = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  // Redirect wins over increment; the increment wraps naturally at 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= ADDR_W'(RESET_PC);
    end else if (load) begin
      pc <= load_pc;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding instruction fetch FSM (optional INSTR_FETCH_ERR_EN wrap trap)
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int RESET_PC = DEF_RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_rvalid,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               redirect_en,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  pc,
  output logic               fetch_err
);

  fetch_state_t state, next_state;
  logic ir_load, ir_clr, pc_inc;
  logic err_q, err_d;

  pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk     (clk),
    .reset   (reset),
    .load    (redirect_en),
    .load_pc (redirect_pc),
    .inc     (pc_inc),
    .pc      (pc)
  );

  assign mem_addr = pc;

`ifdef INSTR_FETCH_ERR_EN
  assign err_d = err_q | (pc_inc & (&pc));

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`else
  assign err_d = 1'b0;
  assign err_q = 1'b0;
`endif

  assign fetch_err = err_q;

  // REQ with mem_req low (just out of reset, or trapped) stays put until a strobe is issued.
  always_comb begin
    next_state = state;
    ir_load    = 1'b0;
    ir_clr     = 1'b0;
    pc_inc     = 1'b0;
    unique case (state)
      ST_REQ: begin
        if (redirect_en)  next_state = ST_REQ;
        else if (mem_req) next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (redirect_en) begin
          next_state = mem_rvalid ? ST_REQ : ST_DRAIN;
        end else if (mem_rvalid) begin
          ir_load    = 1'b1;
          pc_inc     = 1'b1;
          next_state = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect_en) begin
          next_state = ST_REQ;
        end else if (ir_ready) begin
          ir_clr     = 1'b1;
          next_state = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (mem_rvalid) next_state = ST_REQ;
      end
      default: next_state = ST_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_REQ;
      ir       <= '0;
      ir_valid <= 1'b0;
      mem_req  <= 1'b0;
    end else begin
      state   <= next_state;
      mem_req <= (next_state == ST_REQ) && !err_d;
      if (ir_load) ir <= mem_rdata;
      if (redirect_en || ir_clr) ir_valid <= 1'b0;
      else if (ir_load)          ir_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed and randomized checks of instr_fetch against a transaction model
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] ir;
  logic        ir_valid;
  logic        ir_ready = 1'b1;
  logic        redirect_en = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] pc;
  logic        fetch_err;

  int checks = 0;
  int failures = 0;

  // memory model state
  int          lat = 1;
  int          cnt = 0;
  logic [15:0] raddr = 16'h0000;
  logic        use_ovr = 1'b0;
  logic [15:0] ovr = 16'h0000;

  instr_fetch #(.ADDR_W(16), .RESET_PC(0)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .ir          (ir),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a ^ 16'h5A5A) + {a[7:0], a[15:8]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; sample #1 after the edge, then the memory responds to earlier strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = use_ovr ? ovr : mem_word(raddr);
      end
    end
    if (mem_req) begin
      cnt   = lat;
      raddr = mem_addr;
    end
  endtask

  // transaction-level reference state
  logic [15:0] m_pc, m_ir, m_req_addr;
  logic        m_valid, m_out, m_disc, resp_ok, redir;
  int          delivered;
  logic        quiet;

  initial begin
    // reset and first fetch with a 1-cycle memory
    use_ovr = 1'b1; ovr = 16'h1234; lat = 1;
    tick();
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_ir", 32'(ir), 32'h0);
    chk("rst_ir_valid", 32'(ir_valid), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_fetch_err", 32'(fetch_err), 32'h0);
    reset = 1'b0;
    tick();
    chk("c1_mem_req", 32'(mem_req), 32'h1);
    chk("c1_mem_addr", 32'(mem_addr), 32'h0);
    tick();
    chk("c2_mem_req", 32'(mem_req), 32'h0);
    tick();
    chk("c3_ir", 32'(ir), 32'h1234);
    chk("c3_ir_valid", 32'(ir_valid), 32'h1);
    chk("c3_pc", 32'(pc), 32'h1);

    // hold ir for 10 cycles with ready low
    ir_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_ir", 32'(ir), 32'h1234);
      chk("hold_valid", 32'(ir_valid), 32'h1);
      chk("hold_no_req", 32'(mem_req), 32'h0);
    end
    ir_ready = 1'b1; lat = 4;
    tick();
    chk("release_req", 32'(mem_req), 32'h1);
    chk("release_addr", 32'(mem_addr), 32'h1);

    // redirect while waiting; late word is discarded
    tick();
    redirect_en = 1'b1; redirect_pc = 16'h0040; ovr = 16'hDEAD; lat = 2;
    tick();
    redirect_en = 1'b0;
    chk("drain_pc", 32'(pc), 32'h40);
    chk("drain_valid", 32'(ir_valid), 32'h0);
    chk("drain_req", 32'(mem_req), 32'h0);
    tick();
    chk("drain_req2", 32'(mem_req), 32'h0);
    tick();
    chk("drain_rvalid_cycle_req", 32'(mem_req), 32'h0);
    ovr = 16'hBEEF;
    tick();
    chk("after_drain_req", 32'(mem_req), 32'h1);
    chk("after_drain_addr", 32'(mem_addr), 32'h40);
    chk("after_drain_valid", 32'(ir_valid), 32'h0);
    chk("after_drain_ir", 32'(ir), 32'h1234);

    // redirect coincident with rvalid
    tick();
    tick();
    redirect_en = 1'b1; redirect_pc = 16'h0080; lat = 1; use_ovr = 1'b0; ir_ready = 1'b0;
    tick();
    redirect_en = 1'b0;
    chk("coinc_req", 32'(mem_req), 32'h1);
    chk("coinc_addr", 32'(mem_addr), 32'h80);
    chk("coinc_valid", 32'(ir_valid), 32'h0);
    chk("coinc_ir", 32'(ir), 32'h1234);
    chk("coinc_pc", 32'(pc), 32'h80);

    // fetch at 0x80, then redirect to the top of memory and wrap
    tick();
    tick();
    chk("f80_valid", 32'(ir_valid), 32'h1);
    chk("f80_ir", 32'(ir), 32'(mem_word(16'h0080)));
    chk("f80_pc", 32'(pc), 32'h81);
    redirect_en = 1'b1; redirect_pc = 16'hFFFF;
    tick();
    redirect_en = 1'b0;
    chk("top_req", 32'(mem_req), 32'h1);
    chk("top_addr", 32'(mem_addr), 32'hFFFF);
    chk("top_valid", 32'(ir_valid), 32'h0);
    tick();
    tick();
    chk("wrap_pc", 32'(pc), 32'h0);
    chk("wrap_ir", 32'(ir), 32'(mem_word(16'hFFFF)));
    chk("wrap_valid", 32'(ir_valid), 32'h1);
    ir_ready = 1'b1;
    tick();
`ifdef INSTR_FETCH_ERR_EN
    chk("wrap_err", 32'(fetch_err), 32'h1);
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (mem_req) quiet = 1'b0;
      redirect_en = (i == 2);
      redirect_pc = 16'h0010;
      tick();
    end
    redirect_en = 1'b0;
    chk("wrap_no_req", 32'(quiet), 32'h1);
    chk("wrap_redirect_pc", 32'(pc), 32'h10);
    chk("wrap_err_sticky", 32'(fetch_err), 32'h1);
`else
    chk("wrap_err", 32'(fetch_err), 32'h0);
    chk("wrap_req", 32'(mem_req), 32'h1);
    chk("wrap_addr", 32'(mem_addr), 32'h0);
`endif

    // randomized phase against the transaction model
    reset = 1'b1;
    tick();
    cnt = 0; mem_rvalid = 1'b0; redirect_en = 1'b0;
    reset = 1'b0;
    chk("rnd_rst_err", 32'(fetch_err), 32'h0);
    m_pc = 16'h0000; m_ir = 16'h0000; m_valid = 1'b0;
    m_out = 1'b0; m_disc = 1'b0; m_req_addr = 16'h0000;
    delivered = 0;
    for (int c = 0; c < 600; c++) begin
      lat = $urandom_range(1, 3);
      tick();
      chk("rnd_pc", 32'(pc), 32'(m_pc));
      chk("rnd_valid", 32'(ir_valid), 32'(m_valid));
      chk("rnd_ir", 32'(ir), 32'(m_ir));
      resp_ok = mem_rvalid && m_out && !m_disc;
      if (mem_rvalid) begin
        m_out  = 1'b0;
        m_disc = 1'b0;
      end
      if (mem_req) begin
        chk("rnd_addr", 32'(mem_addr), 32'(m_pc));
        chk("rnd_single_outstanding", 32'(m_out), 32'h0);
        m_out      = 1'b1;
        m_req_addr = m_pc;
      end
      ir_ready    = 1'($urandom_range(0, 1));
      redir       = !mem_req && ($urandom_range(0, 9) == 0);
      redirect_en = redir;
      redirect_pc = 16'($urandom_range(0, 16'hF000));
      if (redir && m_out && !mem_rvalid) m_disc = 1'b1;
      if (redir) begin
        m_pc    = redirect_pc;
        m_valid = 1'b0;
      end else if (resp_ok) begin
        m_ir    = mem_word(m_req_addr);
        m_valid = 1'b1;
        m_pc    = m_pc + 16'h0001;
        delivered++;
      end else if (m_valid && ir_ready) begin
        m_valid = 1'b0;
      end
    end
    redirect_en = 1'b0;
    chk("rnd_throughput", 32'(delivered >= 20), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
